if_id_stage: RTL and testbench

//  IF/ID pipeline stage between the I-cache fetch port and decode. Tracks one

---
 rtl/rv32i_types_pkg.sv | 20 ++
 rtl/if_id_stage_hold_buf.sv | 43 ++++
 rtl/if_id_stage.sv | 119 +++++++++++
 tb/tb_if_id_stage.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types_pkg.sv
// Shared RV32I pipeline types for the fetch/decode boundary.
// Holds the fetch FSM encoding, bubble constant and IF/ID bundle.
package rv32i_types;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        READY,
        WAIT,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            valid;
    } if_id_t;

endpackage

// File: rtl/if_id_stage_hold_buf.sv
// One-entry skid buffer for an instruction returned while decode stalls.
// Clear wins over load so a flush always empties the entry.
module if_id_hold_buf
    import rv32i_types::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] instr_i,
    output if_id_t          hold_o
);

    if_id_t hold_q;
    if_id_t hold_d;

    // Next entry: clear drops it, load captures a fresh instruction.
    always_comb begin
        hold_d = hold_q;
        if (clear_i) begin
            hold_d.valid = 1'b0;
        end else if (load_i) begin
            hold_d.pc    = pc_i;
            hold_d.instr = instr_i;
            hold_d.valid = 1'b1;
        end
    end

    // Entry register with synchronous reset to an empty bubble.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q.pc    <= '0;
            hold_q.instr <= NOP_INSTR;
            hold_q.valid <= 1'b0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign hold_o = hold_q;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID stage: tracks one outstanding I-cache fetch and feeds decode.
// Stalled responses park in a skid buffer; PCSrc flushes everything.
module if_id_stage
    import rv32i_types::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] IF_pc,
    input  logic            IF_read,
    input  logic [XLEN-1:0] IF_rdata,
    input  logic            IF_resp,
    input  logic            if_id_write,
    input  logic            PCSrc,
    output logic            IF_ready,
    output logic [XLEN-1:0] ID_pc,
    output logic [XLEN-1:0] ID_instr,
    output logic            ID_valid,
    output logic [4:0]      ID_RS1,
    output logic [4:0]      ID_RS2,
    output logic [4:0]      ID_RD
);

    fetch_state_t    state_q;
    logic [XLEN-1:0] req_pc_q;
    if_id_t          id_q;
    if_id_t          id_d;
    if_id_t          hold;

    logic issue;
    logic resp_ok;
    logic hold_load;
    logic hold_clear;

    // A response only counts when it answers a live fetch.
    assign IF_ready   = (state_q == READY) & ~hold.valid & ~PCSrc;
    assign issue      = IF_read & IF_ready;
    assign resp_ok    = IF_resp & (state_q == WAIT) & ~PCSrc;
    assign hold_load  = resp_ok & ~if_id_write;
    assign hold_clear = PCSrc | (if_id_write & hold.valid);

    if_id_hold_buf u_hold (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (hold_load),
        .clear_i (hold_clear),
        .pc_i    (req_pc_q),
        .instr_i (IF_rdata),
        .hold_o  (hold)
    );

    // Fetch FSM: one request in flight, flushed fetches drain in DROP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= READY;
            req_pc_q <= '0;
        end else begin
            unique case (state_q)
                READY: begin
                    if (issue) begin
                        state_q  <= WAIT;
                        req_pc_q <= IF_pc;
                    end
                end
                WAIT: begin
                    if (IF_resp) begin
                        state_q <= READY;
                    end else if (PCSrc) begin
                        state_q <= DROP;
                    end
                end
                DROP: begin
                    if (IF_resp) begin
                        state_q <= READY;
                    end
                end
                default: state_q <= READY;
            endcase
        end
    end

    // Decode register update: flush, buffered, direct, bubble, stall.
    always_comb begin
        id_d = id_q;
        if (PCSrc) begin
            id_d.valid = 1'b0;
            id_d.instr = NOP_INSTR;
        end else if (if_id_write) begin
            if (hold.valid) begin
                id_d = hold;
            end else if (resp_ok) begin
                id_d.pc    = req_pc_q;
                id_d.instr = IF_rdata;
                id_d.valid = 1'b1;
            end else begin
                id_d.valid = 1'b0;
                id_d.instr = NOP_INSTR;
            end
        end
    end

    // Decode register with synchronous reset to a bubble at PC 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_q.pc    <= '0;
            id_q.instr <= NOP_INSTR;
            id_q.valid <= 1'b0;
        end else begin
            id_q <= id_d;
        end
    end

    assign ID_pc    = id_q.pc;
    assign ID_instr = id_q.instr;
    assign ID_valid = id_q.valid;
    assign ID_RS1   = id_q.instr[19:15];
    assign ID_RS2   = id_q.instr[24:20];
    assign ID_RD    = id_q.instr[11:7];

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios
// plus a randomized run against a queue-based reference model.
module tb_if_id_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] IF_pc;
    logic        IF_read;
    logic [31:0] IF_rdata;
    logic        IF_resp;
    logic        if_id_write;
    logic        PCSrc;
    logic        IF_ready;
    logic [31:0] ID_pc;
    logic [31:0] ID_instr;
    logic        ID_valid;
    logic [4:0]  ID_RS1;
    logic [4:0]  ID_RS2;
    logic [4:0]  ID_RD;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    if_id_stage dut (
        .clk         (clk),
        .rst         (rst),
        .IF_pc       (IF_pc),
        .IF_read     (IF_read),
        .IF_rdata    (IF_rdata),
        .IF_resp     (IF_resp),
        .if_id_write (if_id_write),
        .PCSrc       (PCSrc),
        .IF_ready    (IF_ready),
        .ID_pc       (ID_pc),
        .ID_instr    (ID_instr),
        .ID_valid    (ID_valid),
        .ID_RS1      (ID_RS1),
        .ID_RS2      (ID_RS2),
        .ID_RD       (ID_RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        IF_read     = 1'b0;
        IF_resp     = 1'b0;
        PCSrc       = 1'b0;
        if_id_write = 1'b1;
        IF_pc       = 32'h0;
        IF_rdata    = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        IF_read = 1'b1;
        IF_pc = 32'h40;
        IF_resp = 1'b1;
        IF_rdata = 32'hFFFF_FFFF;
        if_id_write = 1'b1;
        PCSrc = 1'b0;
        step();
        step();
        rst = 1'b0;
        idle();
        #1;
        total++;
        if (ID_instr !== NOP) $display("FAIL reset_instr got %h want %h", ID_instr, NOP);
        else passed++;
        total++;
        if (ID_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", ID_valid);
        else passed++;
        total++;
        if (ID_pc !== 32'h0) $display("FAIL reset_pc got %h want 0", ID_pc);
        else passed++;
        total++;
        if (IF_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", IF_ready);
        else passed++;
        IF_resp = 1'b1;
        IF_rdata = 32'h1234_5678;
        step();
        IF_resp = 1'b0;
        #1;
        total++;
        if (ID_valid !== 1'b0) $display("FAIL spurious_valid got %b want 0", ID_valid);
        else passed++;
    endtask

    task automatic test_streaming();
        idle();
        IF_read = 1'b1;
        IF_pc = 32'h60;
        step();
        IF_read = 1'b0;
        IF_resp = 1'b1;
        IF_rdata = 32'h00A0_0093;
        step();
        IF_resp = 1'b0;
        #1;
        total++;
        if (ID_pc !== 32'h60) $display("FAIL stream_pc got %h want 60", ID_pc);
        else passed++;
        total++;
        if (ID_instr !== 32'h00A0_0093) $display("FAIL stream_instr got %h want 00a00093", ID_instr);
        else passed++;
        total++;
        if (ID_RD !== 5'd1) $display("FAIL stream_rd got %0d want 1", ID_RD);
        else passed++;
        total++;
        if (ID_valid !== 1'b1) $display("FAIL stream_valid got %b want 1", ID_valid);
        else passed++;
        total++;
        if (IF_ready !== 1'b1) $display("FAIL stream_ready got %b want 1", IF_ready);
        else passed++;
        step();
        total++;
        if (ID_valid !== 1'b0 || ID_pc !== 32'h60)
            $display("FAIL bubble got v=%b pc=%h want v=0 pc=60", ID_valid, ID_pc);
        else passed++;
    endtask

    task automatic test_stall();
        idle();
        IF_read = 1'b1;
        IF_pc = 32'h70;
        step();
        IF_read = 1'b0;
        if_id_write = 1'b0;
        IF_resp = 1'b1;
        IF_rdata = 32'h0020_81B3;
        step();
        IF_resp = 1'b0;
        IF_read = 1'b1;
        IF_pc = 32'h200;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (IF_ready !== 1'b0 || ID_valid !== 1'b0 || ID_instr !== NOP)
                $display("FAIL stall_hold%0d got rdy=%b v=%b i=%h want 0 0 %h",
                         i, IF_ready, ID_valid, ID_instr, NOP);
            else passed++;
            if (i < 2) step();
        end
        IF_read = 1'b0;
        if_id_write = 1'b1;
        step();
        total++;
        if (ID_instr !== 32'h0020_81B3 || ID_pc !== 32'h70 || ID_valid !== 1'b1)
            $display("FAIL stall_release got i=%h pc=%h v=%b want 002081b3 70 1",
                     ID_instr, ID_pc, ID_valid);
        else passed++;
        total++;
        if (ID_RS1 !== 5'd1 || ID_RS2 !== 5'd2)
            $display("FAIL stall_rs got rs1=%0d rs2=%0d want 1 2", ID_RS1, ID_RS2);
        else passed++;
        total++;
        if (IF_ready !== 1'b1) $display("FAIL stall_ready got %b want 1", IF_ready);
        else passed++;
    endtask

    task automatic test_flush_inflight();
        idle();
        IF_read = 1'b1;
        IF_pc = 32'h64;
        step();
        IF_read = 1'b0;
        PCSrc = 1'b1;
        step();
        PCSrc = 1'b0;
        #1;
        total++;
        if (ID_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", ID_valid);
        else passed++;
        total++;
        if (IF_ready !== 1'b0) $display("FAIL flush_drop_ready got %b want 0", IF_ready);
        else passed++;
        step();
        IF_resp = 1'b1;
        IF_rdata = 32'hDEAD_BEEF;
        step();
        IF_resp = 1'b0;
        #1;
        total++;
        if (ID_valid !== 1'b0 || ID_instr !== NOP)
            $display("FAIL flush_discard got v=%b i=%h want 0 %h", ID_valid, ID_instr, NOP);
        else passed++;
        total++;
        if (IF_ready !== 1'b1) $display("FAIL flush_after_ready got %b want 1", IF_ready);
        else passed++;
        step();
        total++;
        if (ID_instr === 32'hDEAD_BEEF) $display("FAIL flush_late got %h want %h", ID_instr, NOP);
        else passed++;
    endtask

    task automatic test_flush_same_cycle();
        idle();
        IF_read = 1'b1;
        IF_pc = 32'h80;
        step();
        IF_read = 1'b0;
        IF_resp = 1'b1;
        IF_rdata = 32'h1111_1111;
        PCSrc = 1'b1;
        step();
        IF_resp = 1'b0;
        PCSrc = 1'b0;
        #1;
        total++;
        if (ID_valid !== 1'b0 || ID_instr !== NOP)
            $display("FAIL same_cycle got v=%b i=%h want 0 %h", ID_valid, ID_instr, NOP);
        else passed++;
        total++;
        if (IF_ready !== 1'b1) $display("FAIL same_cycle_ready got %b want 1", IF_ready);
        else passed++;
        IF_read = 1'b1;
        IF_pc = 32'h84;
        step();
        IF_read = 1'b0;
        if_id_write = 1'b0;
        IF_resp = 1'b1;
        IF_rdata = 32'h2222_2222;
        step();
        IF_resp = 1'b0;
        #1;
        total++;
        if (IF_ready !== 1'b0) $display("FAIL hold_full_ready got %b want 0", IF_ready);
        else passed++;
        PCSrc = 1'b1;
        step();
        PCSrc = 1'b0;
        if_id_write = 1'b1;
        #1;
        total++;
        if (IF_ready !== 1'b1) $display("FAIL hold_flush_ready got %b want 1", IF_ready);
        else passed++;
        step();
        total++;
        if (ID_valid !== 1'b0 || ID_instr !== NOP)
            $display("FAIL hold_flush got v=%b i=%h want 0 %h", ID_valid, ID_instr, NOP);
        else passed++;
    endtask

    task automatic test_random();
        ent_t        q[$];
        ent_t        e;
        bit          m_out;
        bit          m_alive;
        int          m_cnt;
        logic [31:0] m_pc;
        logic [31:0] m_instr;
        bit          exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        bit          exp_ready;
        bit          acc;
        bit          resp_alive;
        int          delivered;
        m_out = 0;
        m_alive = 0;
        m_cnt = 0;
        m_pc = 0;
        m_instr = 0;
        delivered = 0;
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_valid = 0;
        exp_pc = 0;
        exp_instr = NOP;
        for (int c = 0; c < 3000; c++) begin
            IF_resp = 1'b0;
            IF_rdata = $urandom;
            if (m_out && m_cnt == 0) begin
                IF_resp = 1'b1;
                IF_rdata = m_instr;
            end else if (!m_out && ($urandom % 10) == 0) begin
                IF_resp = 1'b1;
            end
            IF_read = $urandom_range(0, 1);
            IF_pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            PCSrc = (($urandom % 8) == 0);
            if_id_write = (($urandom % 4) != 0);
            #1;
            exp_ready = !m_out && q.size() == 0 && !PCSrc;
            total++;
            if (IF_ready !== exp_ready)
                $display("FAIL rnd_ready c=%0d got %b want %b", c, IF_ready, exp_ready);
            else passed++;
            @(posedge clk);
            acc = IF_read && exp_ready;
            resp_alive = 0;
            if (m_out) begin
                if (m_cnt == 0) begin
                    m_out = 0;
                    resp_alive = m_alive;
                end else begin
                    m_cnt--;
                end
            end
            if (PCSrc) begin
                q.delete();
                m_alive = 0;
                exp_valid = 0;
                exp_instr = NOP;
            end else begin
                if (resp_alive) q.push_back('{pc: m_pc, instr: m_instr});
                if (if_id_write) begin
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        exp_valid = 1;
                        exp_pc = e.pc;
                        exp_instr = e.instr;
                        delivered++;
                    end else begin
                        exp_valid = 0;
                        exp_instr = NOP;
                    end
                end
            end
            if (acc) begin
                m_out = 1;
                m_alive = 1;
                m_cnt = $urandom_range(0, 3);
                m_pc = IF_pc;
                m_instr = $urandom;
            end
            #1;
            total++;
            if (ID_valid !== exp_valid || ID_instr !== exp_instr ||
                (exp_valid && ID_pc !== exp_pc))
                $display("FAIL rnd_id c=%0d got v=%b pc=%h i=%h want v=%b pc=%h i=%h",
                         c, ID_valid, ID_pc, ID_instr, exp_valid, exp_pc, exp_instr);
            else passed++;
            total++;
            if (ID_RS1 !== exp_instr[19:15] || ID_RS2 !== exp_instr[24:20] ||
                ID_RD !== exp_instr[11:7])
                $display("FAIL rnd_regs c=%0d got %0d %0d %0d want %0d %0d %0d",
                         c, ID_RS1, ID_RS2, ID_RD,
                         exp_instr[19:15], exp_instr[24:20], exp_instr[11:7]);
            else passed++;
        end
        total++;
        if (delivered < 100) $display("FAIL rnd_activity got %0d want >=100", delivered);
        else passed++;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_streaming();
        test_stall();
        test_flush_inflight();
        test_flush_same_cycle();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
